// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR generator and its sequence checker.
// Both sides take the polynomial from here so they cannot drift apart.
package lfsr_pkg;

    localparam int LFSR_WIDTH = 8;

    // x^8 + x^6 + x^5 + x^4 + 1; feedback = d[7] ^ d[5] ^ d[4] ^ d[3]
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // One step of the Fibonacci LFSR: shift left, feedback into bit 0.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
        input logic [LFSR_WIDTH-1:0] d,
        input logic [LFSR_WIDTH-1:0] taps
    );
        return {d[LFSR_WIDTH-2:0], ^(d & taps)};
    endfunction

endpackage

// File: rtl/lfsr_err_popcnt.sv
// Combinational population count of a mismatch vector (received ^ expected).
// Used only when per-bit error accounting is built in (LFSR_CHK_BITERR_EN).
module lfsr_err_popcnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_diff,
    output logic [CNT_W-1:0] o_count
);

    // Sum the set bits of the difference vector.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + CNT_W'(i_diff[i]);
        end
    end

endmodule

// File: rtl/lfsr_seq_checker.sv
// LFSR sequence checker: hunts for a run of correctly chained bytes, then
// predicts the stream locally and flags every byte that deviates.
// Optional macro LFSR_CHK_BITERR_EN adds a saturating bit-error counter.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int                     WIDTH     = LFSR_WIDTH,
    parameter logic [LFSR_WIDTH-1:0]  TAPS      = LFSR_TAPS,
    parameter int                     LOCK_CNT  = 4,
    parameter int                     LOSS_CNT  = 3,
    parameter int                     ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 data_valid,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef LFSR_CHK_BITERR_EN
    ,
    output logic [ERR_CNT_W-1:0] bit_err_count
`endif
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    chk_state_t           r_state;
    chk_state_t           w_state_nxt;
    logic [MATCH_W-1:0]   r_match_cnt, w_match_nxt;
    logic [MISS_W-1:0]    r_miss_cnt,  w_miss_nxt;
    logic [WIDTH-1:0]     r_seed,      w_seed_nxt;
    logic                 r_seed_ok,   w_seed_ok_nxt;
    logic [WIDTH-1:0]     r_expected,  w_expected_nxt;
    logic                 r_locked,    w_locked_nxt;
    logic                 r_err_pulse, w_err_pulse_nxt;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic                 w_err_inc;

    // Next-state and datapath decisions for the hunt/locked FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_match_nxt     = r_match_cnt;
        w_miss_nxt      = r_miss_cnt;
        w_seed_nxt      = r_seed;
        w_seed_ok_nxt   = r_seed_ok;
        w_expected_nxt  = r_expected;
        w_locked_nxt    = r_locked;
        w_err_pulse_nxt = 1'b0;
        w_err_inc       = 1'b0;
        if (data_valid) begin
            case (r_state)
                HUNT: begin
                    if (r_seed_ok && (data_in == lfsr_next(r_seed, TAPS))) begin
                        w_match_nxt = r_match_cnt + MATCH_W'(1);
                    end else begin
                        w_match_nxt = '0;
                    end
                    w_seed_nxt    = data_in;
                    // All-zero is the LFSR lock-up state and can never seed a chain.
                    w_seed_ok_nxt = |data_in;
                    if (w_match_nxt == MATCH_W'(LOCK_CNT)) begin
                        w_state_nxt    = LOCKED;
                        w_expected_nxt = lfsr_next(data_in, TAPS);
                        w_locked_nxt   = 1'b1;
                        w_match_nxt    = '0;
                        w_miss_nxt     = '0;
                    end
                end
                LOCKED: begin
                    // Prediction always advances, so a corrupted byte costs one error only.
                    w_expected_nxt = lfsr_next(r_expected, TAPS);
                    if (data_in == r_expected) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err_pulse_nxt = 1'b1;
                        w_err_inc       = 1'b1;
                        w_miss_nxt      = r_miss_cnt + MISS_W'(1);
                        if (w_miss_nxt == MISS_W'(LOSS_CNT)) begin
                            w_state_nxt   = HUNT;
                            w_locked_nxt  = 1'b0;
                            w_match_nxt   = '0;
                            w_miss_nxt    = '0;
                            w_seed_nxt    = data_in;
                            w_seed_ok_nxt = |data_in;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    // State, status and saturating error counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HUNT;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_seed      <= '0;
            r_seed_ok   <= 1'b0;
            r_expected  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_seed      <= w_seed_nxt;
            r_seed_ok   <= w_seed_ok_nxt;
            r_expected  <= w_expected_nxt;
            r_locked    <= w_locked_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            if (w_err_inc && (r_err_count != {ERR_CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

`ifdef LFSR_CHK_BITERR_EN
    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SUM_W = ((ERR_CNT_W > POP_W) ? ERR_CNT_W : POP_W) + 1;

    logic [POP_W-1:0]     w_pop;
    logic [SUM_W-1:0]     w_bit_sum;
    logic [ERR_CNT_W-1:0] r_bit_err_count;

    lfsr_err_popcnt #(
        .WIDTH (WIDTH),
        .CNT_W (POP_W)
    ) u_popcnt (
        .i_diff  (data_in ^ r_expected),
        .o_count (w_pop)
    );

    assign w_bit_sum = SUM_W'(r_bit_err_count) + SUM_W'(w_pop);

    // Accumulate mismatched bits alongside the byte counter, clamping at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_err_count <= '0;
        end else if (w_err_inc) begin
            if (|w_bit_sum[SUM_W-1:ERR_CNT_W]) begin
                r_bit_err_count <= {ERR_CNT_W{1'b1}};
            end else begin
                r_bit_err_count <= w_bit_sum[ERR_CNT_W-1:0];
            end
        end
    end

    assign bit_err_count = r_bit_err_count;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: a 16-bit-counter instance and a 2-bit-counter
// instance share one stimulus stream and one behavioural reference model.
// Bit-error checks are included when LFSR_CHK_BITERR_EN is defined.
module tb_lfsr_seq_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic        lk, pl, lk2, pl2;
    logic [15:0] ec;
    logic [1:0]  ec2;
`ifdef LFSR_CHK_BITERR_EN
    logic [15:0] bc;
    logic [1:0]  bc2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_seq_checker #(.ERR_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .locked(lk), .err_pulse(pl), .err_count(ec)
`ifdef LFSR_CHK_BITERR_EN
        , .bit_err_count(bc)
`endif
    );

    lfsr_seq_checker #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .locked(lk2), .err_pulse(pl2), .err_count(ec2)
`ifdef LFSR_CHK_BITERR_EN
        , .bit_err_count(bc2)
`endif
    );

    // ---------------- reference model ----------------
    bit         m_locked;
    bit         m_pulse;
    int         m_err;
    int         m_bits;
    int         m_miss;
    logic [7:0] m_exp;
    logic [7:0] hist[$];

    function automatic logic [7:0] nxt(input logic [7:0] d);
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    endfunction

    // True when the last LOCK_CNT+1 hunt bytes form an unbroken chain from a nonzero start.
    function automatic bit chain_ok();
        if (hist.size() != LOCK_CNT + 1) return 1'b0;
        if (hist[0] == 8'h00) return 1'b0;
        for (int i = 1; i < hist.size(); i++)
            if (hist[i] != nxt(hist[i-1])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic model_update(input logic [7:0] d, input bit v, input bit r);
        m_pulse = 1'b0;
        if (r) begin
            m_locked = 1'b0; m_err = 0; m_bits = 0; m_miss = 0; m_exp = 8'h00;
            hist.delete();
        end else if (v) begin
            if (!m_locked) begin
                hist.push_back(d);
                if (hist.size() > LOCK_CNT + 1) void'(hist.pop_front());
                if (chain_ok()) begin
                    m_locked = 1'b1; m_exp = nxt(d); m_miss = 0;
                    hist.delete();
                end
            end else begin
                if (d == m_exp) begin
                    m_miss = 0;
                end else begin
                    m_pulse = 1'b1; m_err++; m_bits += $countones(d ^ m_exp); m_miss++;
                end
                m_exp = nxt(m_exp);
                if (m_miss == LOSS_CNT) begin
                    m_locked = 1'b0; m_miss = 0;
                    hist.delete(); hist.push_back(d);
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, advance the model, sample 1ns after the edge.
    task automatic step(input logic [7:0] d, input bit v, input bit r);
        @(negedge clk);
        data_in = d; data_valid = v; reset = r;
        @(posedge clk);
        model_update(d, v, r);
        #1;
    endtask

    task automatic do_reset();
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
    endtask

    task automatic do_lock();
        logic [7:0] d;
        d = 8'h01;
        for (int i = 0; i < 5; i++) begin
            step(d, 1'b1, 1'b0);
            d = nxt(d);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (lk !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b want=0", lk); end
        checks++; if (pl !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b want=0", pl); end
        checks++; if (ec !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", ec); end
        checks++; if (lk2 !== 1'b0 || ec2 !== 2'd0) begin failures++; $display("FAIL reset_dut2 got=%b/%0d want=0/0", lk2, ec2); end
    endtask

    task automatic test_lock();
        logic [7:0] seq [5];
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(seq[i], 1'b1, 1'b0);
            checks++;
            if (lk !== m_locked) begin failures++; $display("FAIL lock_progress[%0d] got=%b want=%b", i, lk, m_locked); end
        end
        checks++; if (lk !== 1'b1) begin failures++; $display("FAIL lock_after_11 got=%b want=1", lk); end
        checks++; if (ec !== 16'd0) begin failures++; $display("FAIL lock_errcount got=%0d want=0", ec); end
    endtask

    task automatic test_single_error();
        step(8'h00, 1'b1, 1'b0);
        checks++; if (pl !== 1'b1) begin failures++; $display("FAIL single_pulse got=%b want=1", pl); end
        checks++; if (ec !== 16'd1) begin failures++; $display("FAIL single_count got=%0d want=1", ec); end
        checks++; if (lk !== 1'b1) begin failures++; $display("FAIL single_locked got=%b want=1", lk); end
`ifdef LFSR_CHK_BITERR_EN
        checks++; if (bc !== 16'd3) begin failures++; $display("FAIL single_bits got=%0d want=3", bc); end
`endif
        step(8'h47, 1'b1, 1'b0);
        checks++; if (pl !== 1'b0) begin failures++; $display("FAIL single_47_pulse got=%b want=0", pl); end
        checks++; if (ec !== 16'd1 || lk !== 1'b1) begin failures++; $display("FAIL single_47_state got=%0d/%b want=1/1", ec, lk); end
    endtask

    task automatic test_loss_relock();
        int base;
        base = m_err;
        for (int i = 0; i < 3; i++) begin
            step(8'hFF, 1'b1, 1'b0);
            checks++;
            if (lk !== (i < 2)) begin failures++; $display("FAIL loss_locked[%0d] got=%b want=%b", i, lk, (i < 2)); end
        end
        checks++; if (ec !== 16'(base + 3)) begin failures++; $display("FAIL loss_count got=%0d want=%0d", ec, base + 3); end
        do_lock();
        checks++; if (lk !== 1'b1) begin failures++; $display("FAIL relock got=%b want=1", lk); end
        checks++; if (ec !== 16'(base + 3)) begin failures++; $display("FAIL relock_count_held got=%0d want=%0d", ec, base + 3); end
    endtask

    task automatic test_valid_gaps();
        do_reset();
        step(8'h01, 1'b1, 1'b0); step(8'h02, 1'b1, 1'b0); step(8'h04, 1'b1, 1'b0);
        step(8'hAA, 1'b0, 1'b0); step(8'h00, 1'b0, 1'b0);
        step(8'h08, 1'b1, 1'b0); step(8'h11, 1'b1, 1'b0);
        checks++; if (lk !== 1'b1) begin failures++; $display("FAIL gap_hunt_lock got=%b want=1", lk); end
        step(8'h23, 1'b1, 1'b0); step(8'h47, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(8'($urandom), 1'b0, 1'b0);
            checks++;
            if (lk !== 1'b1 || pl !== 1'b0) begin failures++; $display("FAIL gap_hold[%0d] got=%b/%b want=1/0", i, lk, pl); end
        end
        step(8'h8E, 1'b1, 1'b0);
        checks++; if (ec !== 16'd0 || pl !== 1'b0) begin failures++; $display("FAIL gap_resume got=%0d/%b want=0/0", ec, pl); end
    endtask

    task automatic test_zero_seed();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(8'h00, 1'b1, 1'b0);
            checks++;
            if (lk !== 1'b0 || lk2 !== 1'b0) begin failures++; $display("FAIL zero_seed[%0d] got=%b/%b want=0/0", i, lk, lk2); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        do_lock();
        for (int i = 0; i < 5; i++) begin
            step(m_exp ^ 8'(1 << $urandom_range(7)), 1'b1, 1'b0);
            step(m_exp, 1'b1, 1'b0);
        end
        checks++; if (ec !== 16'd5) begin failures++; $display("FAIL sat_wide got=%0d want=5", ec); end
        checks++; if (ec2 !== 2'd3) begin failures++; $display("FAIL sat_narrow got=%0d want=3", ec2); end
        checks++; if (lk2 !== 1'b1) begin failures++; $display("FAIL sat_locked got=%b want=1", lk2); end
`ifdef LFSR_CHK_BITERR_EN
        checks++; if (bc !== 16'd5 || bc2 !== 2'd3) begin failures++; $display("FAIL sat_bits got=%0d/%0d want=5/3", bc, bc2); end
`endif
    endtask

    task automatic test_midstream_reset();
        do_reset();
        do_lock();
        step(~m_exp, 1'b1, 1'b0);
        step(m_exp, 1'b1, 1'b0);
        step(m_exp ^ 8'h10, 1'b1, 1'b0);
        checks++; if (ec !== 16'd2 || lk !== 1'b1) begin failures++; $display("FAIL pre_reset got=%0d/%b want=2/1", ec, lk); end
        step(m_exp ^ 8'h01, 1'b1, 1'b1);
        checks++; if (lk !== 1'b0 || ec !== 16'd0 || pl !== 1'b0) begin failures++; $display("FAIL mid_reset got=%b/%0d/%b want=0/0/0", lk, ec, pl); end
        checks++; if (lk2 !== 1'b0 || ec2 !== 2'd0 || pl2 !== 1'b0) begin failures++; $display("FAIL mid_reset2 got=%b/%0d/%b want=0/0/0", lk2, ec2, pl2); end
    endtask

    task automatic test_random();
        logic [7:0] cur, d;
        bit v, r;
        do_reset();
        cur = 8'($urandom_range(255, 1));
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(3) != 0);
            r = ($urandom_range(499) == 0);
            d = 8'($urandom);
            if (v) begin
                if ($urandom_range(149) == 0) cur = 8'($urandom_range(255, 1));
                cur = nxt(cur);
                d = cur;
                if ($urandom_range(99) < 10) d = 8'($urandom);
            end
            step(d, v, r);
            checks++;
            if (lk !== m_locked || pl !== m_pulse || ec !== 16'(m_err)) begin
                failures++;
                $display("FAIL random[%0d] got=%b/%b/%0d want=%b/%b/%0d", n, lk, pl, ec, m_locked, m_pulse, m_err);
            end
            checks++;
            if (lk2 !== m_locked || ec2 !== 2'(sat3(m_err))) begin
                failures++;
                $display("FAIL random2[%0d] got=%b/%0d want=%b/%0d", n, lk2, ec2, m_locked, sat3(m_err));
            end
`ifdef LFSR_CHK_BITERR_EN
            checks++;
            if (bc !== 16'(m_bits) || bc2 !== 2'(sat3(m_bits))) begin
                failures++;
                $display("FAIL random_bits[%0d] got=%0d/%0d want=%0d/%0d", n, bc, bc2, m_bits, sat3(m_bits));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_valid_gaps();
        test_zero_seed();
        test_saturation();
        test_midstream_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
